// File: rtl/fetch_unit.sv
// Fetch stage with credit-limited imem requests, response queue and IF/ID register.
// Redirects flush the queue and drop every response still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          QDEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [CW:0] DEPTH = (CW + 1)'(QDEPTH);

    logic [31:0]   pc_f;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] out_nxt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_cnt;
    logic [CW-1:0] q_nxt;
    logic [CW:0]   used;

    logic [AW-1:0] a_wp;
    logic [AW-1:0] a_rp;
    logic [AW-1:0] q_wp;
    logic [AW-1:0] q_rp;

    logic [31:0] a_mem   [QDEPTH];
    logic [31:0] q_pc    [QDEPTH];
    logic [31:0] q_instr [QDEPTH];

    logic        redirect;
    logic        accept;
    logic        dropping;
    logic        push;
    logic        pop;
    logic        q_empty;
    logic [31:0] branch_pc;

    assign branch_pc = PCBranchD & ~32'h3;
    assign redirect  = PCSrcD && !StallD;
    assign used      = {1'b0, out_cnt} + {1'b0, q_cnt};
    assign q_empty   = (q_cnt == '0);

    // Credit covers both in-flight and queued entries, so a response always fits.
    assign imem_req  = !rst && !StallF && !redirect && (used < DEPTH);
    assign imem_addr = pc_f;
    assign accept    = imem_req && imem_ready;

    assign dropping = (drop_cnt != '0);
    assign push     = imem_rvalid && !dropping && !redirect;
    assign pop      = !StallD && !FlushD && !PCSrcD && !q_empty;

    always_comb begin
        out_nxt = out_cnt;
        if (accept && !imem_rvalid) begin
            out_nxt = out_cnt + CW'(1);
        end else if (!accept && imem_rvalid) begin
            out_nxt = out_cnt - CW'(1);
        end
    end

    always_comb begin
        q_nxt = q_cnt;
        if (push && !pop) begin
            q_nxt = q_cnt + CW'(1);
        end else if (!push && pop) begin
            q_nxt = q_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f     <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            a_wp     <= '0;
            a_rp     <= '0;
        end else begin
            if (redirect) begin
                pc_f <= branch_pc;
            end else if (accept) begin
                pc_f <= pc_f + 32'd4;
            end
            if (accept) begin
                a_wp <= a_wp + AW'(1);
            end
            if (imem_rvalid) begin
                a_rp <= a_rp + AW'(1);
            end
            out_cnt <= out_nxt;
            // Whatever remains in flight after a redirect edge is stale.
            if (redirect) begin
                drop_cnt <= out_nxt;
            end else if (imem_rvalid && dropping) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt <= '0;
            q_wp  <= '0;
            q_rp  <= '0;
        end else if (redirect) begin
            q_cnt <= '0;
            q_wp  <= '0;
            q_rp  <= '0;
        end else begin
            q_cnt <= q_nxt;
            if (push) begin
                q_wp <= q_wp + AW'(1);
            end
            if (pop) begin
                q_rp <= q_rp + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_mem[a_wp] <= pc_f;
        end
        if (push) begin
            q_pc[q_wp]    <= a_mem[a_rp];
            q_instr[q_wp] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd4;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (FlushD || PCSrcD || q_empty) begin
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end else begin
                InstrD   <= q_instr[q_rp];
                PCD      <= q_pc[q_rp];
                PCPlus4D <= q_pc[q_rp] + 32'd4;
                ValidD   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit with an in-order variable-latency imem
// model and a scoreboard of expected decode PCs.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int          QD     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcD = 1'b0;
    logic [31:0] PCBranchD = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP),
        .QDEPTH   (QD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int valid_seen = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   cyc = 0;
    int   lat_min = 1;
    int   lat_max = 1;
    bit   rdy_rand = 1'b0;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic rebase(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    // Instruction memory: in order, latency counted from the accept edge.
    initial begin
        req_t r;
        logic rs;
        forever begin
            @(posedge clk);
            cyc++;
            rs = rst;
            if (rs) begin
                pend.delete();
            end else if (imem_req && imem_ready) begin
                r.addr = imem_addr;
                r.due  = cyc + int'($urandom_range(lat_min, lat_max)) - 1;
                pend.push_back(r);
                check("inflight_le_qdepth", 32'(pend.size() <= QD), 32'd1);
            end
            #1;
            if (!rs && pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                imem_rvalid = 1'b1;
                imem_rdata  = tag(r.addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'd0;
            end
            imem_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Scoreboard: each newly loaded valid decode slot must be the next expected PC.
    initial begin
        logic nd;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            nd = !StallD && !rst;
            @(negedge clk);
            if (nd && ValidD) begin
                check("exp_available", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    last_exp = e;
                    valid_seen++;
                    check("PCD", PCD, e);
                    check("InstrD", InstrD, tag(e));
                    check("PCPlus4D", PCPlus4D, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen0;
        int n;
        rebase(RST_PC);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_ValidD", 32'(ValidD), 32'd0);
        check("rst_InstrD", InstrD, NOP);
        check("rst_PCD", PCD, 32'd0);
        check("rst_PCPlus4D", PCPlus4D, 32'd4);

        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk); #1;
        check("valid_before_3rd_edge", 32'(ValidD), 32'd0);
        @(posedge clk);
        @(negedge clk); #1;
        check("valid_after_3rd_edge", 32'(ValidD), 32'd1);
        check("first_PCD", PCD, RST_PC);
        repeat (8) begin
            @(negedge clk); #1;
            check("no_gap", 32'(ValidD), 32'd1);
        end

        @(posedge clk); #1 StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stall_PCD", PCD, last_exp);
            check("stall_InstrD", InstrD, tag(last_exp));
            check("stall_ValidD", 32'(ValidD), 32'd1);
            if (i == 2) check("stall_credit_stop", 32'(imem_req), 32'd0);
            @(posedge clk); #1;
        end
        StallD = 1'b0;
        repeat (6) @(posedge clk);

        #1 FlushD = 1'b1;
        @(posedge clk); #1 FlushD = 1'b0;
        @(negedge clk); #1;
        check("flush_ValidD", 32'(ValidD), 32'd0);
        check("flush_InstrD", InstrD, NOP);
        @(negedge clk); #1;
        check("after_flush_ValidD", 32'(ValidD), 32'd1);

        @(posedge clk); #1 lat_min = 2; lat_max = 2;
        repeat (8) @(posedge clk);
        #1 PCSrcD = 1'b1; PCBranchD = 32'h0000_0100;
        @(negedge clk); #1;
        check("redir_no_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1 PCSrcD = 1'b0;
        rebase(32'h0000_0100);
        @(negedge clk); #1;
        check("redir_ValidD", 32'(ValidD), 32'd0);
        check("redir_InstrD", InstrD, NOP);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        repeat (10) @(posedge clk);

        #1 lat_min = 1; lat_max = 1;
        repeat (6) @(posedge clk);
        #1 PCSrcD = 1'b1; PCBranchD = 32'h0000_0203;
        @(posedge clk); #1 PCSrcD = 1'b0;
        rebase(32'h0000_0200);
        @(negedge clk); #1;
        check("misalign_req", 32'(imem_req), 32'd1);
        check("misalign_addr", imem_addr, 32'h0000_0200);
        repeat (10) @(posedge clk);

        seen0 = valid_seen;
        #1 rdy_rand = 1'b1; lat_min = 1; lat_max = 5;
        repeat (300) begin
            @(posedge clk); #1;
            StallF = ($urandom_range(0, 4) == 0);
            StallD = ($urandom_range(0, 6) == 0);
            FlushD = ($urandom_range(0, 9) == 0);
        end
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        rdy_rand = 1'b0; lat_min = 1; lat_max = 1;
        repeat (20) @(posedge clk);
        check("random_progress", 32'((valid_seen - seen0) > 20), 32'd1);

        #1 lat_min = 2; lat_max = 2;
        repeat (6) @(posedge clk);
        #1 StallD = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; StallD = 1'b0;
        @(posedge clk); #1 rebase(RST_PC);
        @(negedge clk); #1;
        check("rstm_ValidD", 32'(ValidD), 32'd0);
        check("rstm_InstrD", InstrD, NOP);
        check("rstm_req", 32'(imem_req), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        n = 0;
        while (!ValidD && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("rstm_valid_seen", 32'(ValidD), 32'd1);
        check("rstm_first_PCD", PCD, RST_PC);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
